i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (responder) for the on-chip I2C bus; it answers the controller transactions the be8 core drives on `scl_o`/`sda_o`. It decodes START/STOP, matches a 7-bit address, acknowledges, and converts bus transfers into a byte-wide pointer-addressed memory port, EEPROM style. Intended uses are as a loopback target in the test harness and as a register-file front-end inside `tt_um_obriensp_be8`. No clock stretching: `scl` is input-only.

## Interface
- `ADDR`, 7'h50, target address matched against the first byte's upper 7 bits
- `clk`  in  1  system clock; must run at ≥10× SCL frequency
- `rst_n`  in  1  asynchronous, active-low reset
- `scl_i`  in  1  bus SCL level (asynchronous)
- `sda_i`  in  1  bus SDA level (asynchronous)
- `sda_oe`  out  1  1 = pull SDA low (open-drain); 0 = release
- `mem_addr`  out  8  current pointer, presented with `mem_we`/`mem_re`
- `mem_wdata`  out  8  write byte
- `mem_we`  out  1  one-cycle write strobe
- `mem_re`  out  1  one-cycle read strobe
- `mem_rdata`  in  8  read data, valid the cycle after `mem_re`
- `busy`  out  1  high from an address-matched START until STOP, NACK or mismatch

## Operation
- `scl_i`/`sda_i` pass through 2-FF synchronizers; all edge detection uses the synchronized signals and their previous values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. START is recognised in any state, including mid-byte, and enters ADDR (repeated start). STOP in any state enters IDLE with `sda_oe`=0.
- Data is sampled on SCL rise, MSB first. `sda_oe` changes only on SCL fall.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
- ADDR: shift 8 bits. On the SCL fall after bit 8:
  - if bits[7:1]==`ADDR`, set `sda_oe`=1, set `busy`=1 and go to ADDR_ACK;
  - otherwise go to IDLE without ACK and ignore traffic until the next START.
- ADDR_ACK: on the SCL fall ending the 9th clock, release `sda_oe`. If R/W=0, go to WR_BYTE. If R/W=1, pulse `mem_re` with `mem_addr`=pointer, load `mem_rdata` into the shift register on the next cycle, increment the pointer, drive bit 7, then go to RD_BYTE.
- WR_BYTE: after 8 bits, ACK as above (WR_ACK).
  - First data byte after the address loads the pointer.
  - Each later byte pulses `mem_we` for one cycle with `mem_addr`=pointer and `mem_wdata`=byte, then the pointer increments.
  - The pulse occurs at the SCL fall that asserts the ACK.
- RD_BYTE: `sda_oe` = ~bit for each bit. After the 8th SCL fall, release SDA and go to RD_ACK.
- RD_ACK: sample SDA on the 9th SCL rise.
  - Low (ACK): at the following fall, prefetch as in ADDR_ACK and return to RD_BYTE.
  - High (NACK): go to IDLE with `sda_oe`=0 and `busy`=0.
- Pointer: 8 bits, wraps 0xFF→0x00, persists across transactions and repeated STARTs. Only reset clears it.

## Timing
- Reset values: `sda_oe`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, pointer=0, state IDLE, synchronizers=1.
- `rst_n` low releases SDA immediately (asynchronous), including mid-ACK or mid-read.
- Bus-to-internal latency is 2 clk (synchronizer) plus 1 clk (edge detect). `sda_oe` updates ≤4 clk after the synchronized SCL fall.
- `mem_we`/`mem_re` are exactly 1 clk wide. `mem_addr` is stable during the strobe. `mem_rdata` is captured exactly 1 clk after `mem_re`.
- A START or STOP seen during a byte aborts it: no `mem_we` for a partial byte.

## Test plan
- Write burst: START, 0xA0, 0x10, 0xAB, 0xCD, STOP, each byte ACKed. Expect `mem_we` at addr 0x10 data 0xAB, then addr 0x11 data 0xCD. Pointer ends at 0x12 and `busy` falls at STOP.
- Address mismatch: START, 0xA2, 0x55, STOP. `sda_oe` stays 0 throughout, with no `mem_we`/`mem_re` and `busy`=0.
- Random read: START, 0xA0, 0x20, repeated START, 0xA1; read two bytes with the memory returning 0x5A then 0xC3; controller sends ACK then NACK, then STOP. Bus bits are 0x5A then 0xC3, `mem_re` hits addr 0x20 and 0x21, pointer ends at 0x22, and SDA is released after NACK.
- Wrap-around: START, 0xA0, 0xFF, 0x11, 0x22, STOP. Writes go to 0xFF then 0x00, and the pointer ends at 0x01.
- Abort: STOP after 3 data bits of a write byte. No `mem_we` occurs and the state is IDLE. A following valid write to 0x30 succeeds.
- Reset during ACK: drop `rst_n` while `sda_oe`=1. `sda_oe` goes 0 in the same cycle and the pointer returns to 0.

Source files
------------

// File: rtl/i2c_target_if.sv
// Bus-side and memory-side signals of the I2C target, grouped for the target and its environment.
// mem_we / mem_re are one-clock strobes with mem_addr held stable; mem_rdata is expected one clock after mem_re.
interface i2c_target_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_we;
    logic       mem_re;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, mem_rdata,
        output sda_oe, mem_addr, mem_wdata, mem_we, mem_re, busy
    );

    modport master (
        output scl_i, sda_i, mem_rdata,
        input  sda_oe, mem_addr, mem_wdata, mem_we, mem_re, busy
    );
endinterface

// File: rtl/i2c_target.sv
// EEPROM-style I2C target: 7-bit address match, pointer-addressed byte memory port, no clock stretching.
// dbg_state exposes the protocol FSM state.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic         clk,
    input  logic         rst_n,
    i2c_target_if.slave  bus,
    output logic [2:0]   dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK
    } state_e;

    state_e     state_q, state_d;
    logic       scl_s1_q, scl_s2_q, scl_prev_q;
    logic       sda_s1_q, sda_s2_q, sda_prev_q;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       we_q, we_d;
    logic       re_q, re_d;
    logic       load_q, load_d;
    logic       rw_q, rw_d;
    logic       first_q, first_d;
    logic       nack_q, nack_d;

    logic scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_s1_q   <= bus.scl_i;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= bus.sda_i;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
        end
    end

    assign scl_rise  = scl_s2_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s2_q & scl_prev_q;
    assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        wdata_d  = wdata_q;
        sda_oe_d = sda_oe_q;
        busy_d   = busy_q;
        rw_d     = rw_q;
        first_d  = first_q;
        nack_d   = nack_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        load_d   = re_q;

        // The pointer advances the cycle after a strobe so mem_addr holds through it.
        if (we_q || load_q) ptr_d = ptr_q + 8'd1;
        if (load_q) begin
            shift_d  = bus.mem_rdata;
            sda_oe_d = ~bus.mem_rdata[7];
        end

        if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            load_d   = 1'b0;
        end else if (start_det) begin
            state_d  = S_ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            load_d   = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s2_q};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (shift_q[7:1] == ADDR) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                            state_d  = S_ADDR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        if (rw_q) begin
                            re_d    = 1'b1;
                            state_d = S_RD_BYTE;
                        end else begin
                            first_d = 1'b1;
                            state_d = S_WR_BYTE;
                        end
                    end
                end
                S_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s2_q};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        state_d  = S_WR_ACK;
                        if (first_q) begin
                            ptr_d   = shift_q;
                            first_d = 1'b0;
                        end else begin
                            we_d    = 1'b1;
                            wdata_d = shift_q;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = S_WR_BYTE;
                    end
                end
                S_RD_BYTE: begin
                    if (scl_fall && !load_q) begin
                        cnt_d   = cnt_q + 4'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                        if (cnt_q == 4'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_RD_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        nack_d = sda_s2_q;
                    end else if (scl_fall) begin
                        if (nack_q) begin
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                            state_d  = S_IDLE;
                        end else begin
                            re_d    = 1'b1;
                            cnt_d   = 4'd0;
                            state_d = S_RD_BYTE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            shift_q  <= 8'h00;
            ptr_q    <= 8'h00;
            wdata_q  <= 8'h00;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            load_q   <= 1'b0;
            rw_q     <= 1'b0;
            first_q  <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            wdata_q  <= wdata_d;
            sda_oe_q <= sda_oe_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            re_q     <= re_d;
            load_q   <= load_d;
            rw_q     <= rw_d;
            first_q  <= first_d;
            nack_q   <= nack_d;
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.mem_addr  = ptr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_re    = re_q;
    assign bus.busy      = busy_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller on an open-drain SDA model plus a registered memory.
module tb_i2c_target;
  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic [2:0] dbg_state;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  i2c_target_if bus();
  assign bus.scl_i = scl_drv;
  assign bus.sda_i = sda_drv & ~bus.sda_oe;

  i2c_target #(.ADDR(7'h50)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  logic [7:0]  mem [256];
  logic [15:0] we_log[$];
  logic [7:0]  re_log[$];
  logic [15:0] exp_q[$];
  logic        oe_seen = 1'b0;
  logic        wide_seen = 1'b0;
  logic        prev_we = 1'b0;
  logic        prev_re = 1'b0;

  always @(posedge clk) if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];

  always @(negedge clk) begin
    if (bus.mem_we) we_log.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.mem_re) re_log.push_back(bus.mem_addr);
    if ((bus.mem_we && prev_we) || (bus.mem_re && prev_re)) wide_seen = 1'b1;
    if (bus.sda_oe) oe_seen = 1'b1;
    prev_we = bus.mem_we;
    prev_re = bus.mem_re;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic i2c_start();
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    sda_drv = 1'b0; #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; #Q;
    scl_drv = 1'b1; #Q;
    sda_drv = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; #Q;
    scl_drv = 1'b1; #(2*Q);
    scl_drv = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    ack = ~bus.sda_i; #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl_drv = 1'b1;
      #Q; b[i] = bus.sda_i;
      #Q; scl_drv = 1'b0;
      #Q;
    end
    send_bit(~ack);
  endtask

  task automatic clear_logs();
    we_log.delete();
    re_log.delete();
    exp_q.delete();
    oe_seen = 1'b0;
    wide_seen = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got=%b want=0", bus.sda_oe); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b want=00", bus.mem_we, bus.mem_re); end
    checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h want=00", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got=%h want=00", bus.mem_wdata); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    rst_n = 1'b1;
    #Q;
  endtask

  task automatic test_write_burst();
    logic ack;
    logic [7:0] bytes [4];
    bytes[0] = 8'hA0; bytes[1] = 8'h10; bytes[2] = 8'hAB; bytes[3] = 8'hCD;
    clear_logs();
    exp_q.push_back(16'h10AB);
    exp_q.push_back(16'h11CD);
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i], ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_ack byte%0d got=%b want=1", i, ack); end
      if (i == 0) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wr_busy_on got=%b want=1", bus.busy); end
      end
    end
    i2c_stop();
    #Q;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_busy_off got=%b want=0", bus.busy); end
    checks++; if (we_log.size() != exp_q.size()) begin errors++; $display("FAIL wr_count got=%0d want=%0d", we_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < we_log.size(); i++) begin
      checks++; if (we_log[i] !== exp_q[i]) begin errors++; $display("FAIL wr_data%0d got=%h want=%h", i, we_log[i], exp_q[i]); end
    end
    checks++; if (bus.mem_addr !== 8'h12) begin errors++; $display("FAIL wr_ptr got=%h want=12", bus.mem_addr); end
    checks++; if (wide_seen !== 1'b0) begin errors++; $display("FAIL wr_strobe_width got=wide want=single"); end
  endtask

  task automatic test_mismatch();
    logic ack;
    clear_logs();
    i2c_start();
    write_byte(8'hA2, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mm_ack got=%b want=0", ack); end
    write_byte(8'h55, ack);
    i2c_stop();
    #Q;
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL mm_sda_oe got=%b want=0", oe_seen); end
    checks++; if (we_log.size() != 0 || re_log.size() != 0) begin errors++; $display("FAIL mm_strobes got=%0d/%0d want=0/0", we_log.size(), re_log.size()); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mm_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_random_read();
    logic ack;
    logic [7:0] b0, b1;
    clear_logs();
    mem[8'h20] = 8'h5A;
    mem[8'h21] = 8'hC3;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h20, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rd_addr_ack got=%b want=1", ack); end
    read_byte(b0, 1'b1);
    read_byte(b1, 1'b0);
    checks++; if (b0 !== 8'h5A) begin errors++; $display("FAIL rd_byte0 got=%h want=5a", b0); end
    checks++; if (b1 !== 8'hC3) begin errors++; $display("FAIL rd_byte1 got=%h want=c3", b1); end
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL rd_release got=%b want=0", bus.sda_oe); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rd_busy_nack got=%b want=0", bus.busy); end
    i2c_stop();
    #Q;
    checks++; if (re_log.size() != 2) begin errors++; $display("FAIL rd_count got=%0d want=2", re_log.size()); end
    else begin
      checks++; if (re_log[0] !== 8'h20 || re_log[1] !== 8'h21) begin errors++; $display("FAIL rd_addrs got=%h,%h want=20,21", re_log[0], re_log[1]); end
    end
    checks++; if (we_log.size() != 0) begin errors++; $display("FAIL rd_no_write got=%0d want=0", we_log.size()); end
    checks++; if (bus.mem_addr !== 8'h22) begin errors++; $display("FAIL rd_ptr got=%h want=22", bus.mem_addr); end
  endtask

  task automatic test_wrap();
    logic ack;
    clear_logs();
    exp_q.push_back(16'hFF11);
    exp_q.push_back(16'h0022);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    i2c_stop();
    #Q;
    checks++; if (we_log.size() != exp_q.size()) begin errors++; $display("FAIL wrap_count got=%0d want=%0d", we_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < we_log.size(); i++) begin
      checks++; if (we_log[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_data%0d got=%h want=%h", i, we_log[i], exp_q[i]); end
    end
    checks++; if (bus.mem_addr !== 8'h01) begin errors++; $display("FAIL wrap_ptr got=%h want=01", bus.mem_addr); end
  endtask

  task automatic test_abort();
    logic ack;
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_stop();
    #Q;
    checks++; if (we_log.size() != 0) begin errors++; $display("FAIL abort_no_write got=%0d want=0", we_log.size()); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL abort_state got=%0d want=0", dbg_state); end
    exp_q.push_back(16'h3077);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h30, ack);
    write_byte(8'h77, ack);
    i2c_stop();
    #Q;
    checks++; if (we_log.size() != 1) begin errors++; $display("FAIL abort_follow_count got=%0d want=1", we_log.size()); end
    else begin
      checks++; if (we_log[0] !== exp_q[0]) begin errors++; $display("FAIL abort_follow_data got=%h want=%h", we_log[0], exp_q[0]); end
    end
    checks++; if (bus.mem_addr !== 8'h31) begin errors++; $display("FAIL abort_ptr got=%h want=31", bus.mem_addr); end
  endtask

  task automatic test_reset_during_ack();
    logic ack;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5);
    #50;
    checks++; if (bus.sda_oe !== 1'b1) begin errors++; $display("FAIL rst_ack_oe_before got=%b want=1", bus.sda_oe); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL rst_ack_oe_async got=%b want=0", bus.sda_oe); end
    checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL rst_ack_ptr got=%h want=00", bus.mem_addr); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_ack_busy got=%b want=0", bus.busy); end
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    rst_n = 1'b1; #Q;
    clear_logs();
    exp_q.push_back(16'h4099);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    write_byte(8'h99, ack);
    i2c_stop();
    #Q;
    checks++; if (we_log.size() != 1) begin errors++; $display("FAIL rst_recover_count got=%0d want=1", we_log.size()); end
    else begin
      checks++; if (we_log[0] !== exp_q[0]) begin errors++; $display("FAIL rst_recover_data got=%h want=%h", we_log[0], exp_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_mismatch();
    test_random_read();
    test_wrap();
    test_abort();
    test_reset_during_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
